// File: rtl/imem_fetch_resp.sv
// Instruction-memory fetch responder: a one-entry response register in front of a
// loadable word array. Optional misaligned-fetch trapping is enabled by IMEM_MISALIGN_CHECK_EN.
module imem_fetch_resp #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  input  logic [31:0]           REQ_ADDR,
  output logic                  REQ_READY,
  output logic                  RSP_VALID,
  output logic [31:0]           RSP_DATA,
  output logic                  RSP_ERR,
  input  logic                  RSP_READY,
  input  logic                  LOAD_WE,
  input  logic [DEPTH_LOG2-1:0] LOAD_ADDR,
  input  logic [31:0]           LOAD_DATA,
  output logic [15:0]           FETCH_CNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  out_of_range;
  logic                  req_err;
  logic                  accept;
  logic                  consume;
  logic [31:0]           rsp_data_q;
  logic                  rsp_err_q;
  logic [15:0]           fetch_cnt_q;

  assign rd_idx       = REQ_ADDR[DEPTH_LOG2+1:2];
  assign out_of_range = |REQ_ADDR[31:DEPTH_LOG2+2];

`ifdef IMEM_MISALIGN_CHECK_EN
  assign req_err = out_of_range || (|REQ_ADDR[1:0]);
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, REQ_ADDR[1:0]};
  assign req_err = out_of_range;
`endif

  assign RSP_VALID = (state_q == FULL);
  assign REQ_READY = !RSP_VALID || RSP_READY;
  assign accept    = REQ_VALID && REQ_READY;
  assign consume   = RSP_VALID && RSP_READY;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;
  assign FETCH_CNT = fetch_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (RSP_READY) state_d = accept ? FULL : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // The memory read sees the pre-edge array, so a same-cycle load returns the old word.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      fetch_cnt_q <= 16'h0;
    end else begin
      if (accept) begin
        rsp_err_q  <= req_err;
        rsp_data_q <= req_err ? NOP_WORD : mem[rd_idx];
      end
      if (consume) fetch_cnt_q <= fetch_cnt_q + 16'd1;
    end
  end

  // Program contents survive reset; loads are simply blocked while it is held.
  always_ff @(posedge CLK) begin
    if (RST && LOAD_WE) mem[LOAD_ADDR] <= LOAD_DATA;
  end

endmodule
